// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encodings, seeds, speed width and mode helpers for led_pattern_seq
// Build option: LED_SEQ_BLINK_EN adds the BLINK mode to the mode cycle.
package led_seq_pkg;
  typedef enum logic [1:0] {
    M_LEFT   = 2'd0,
    M_RIGHT  = 2'd1,
    M_BOUNCE = 2'd2,
    M_BLINK  = 2'd3
  } mode_e;
  localparam logic [15:0] SEED_LEFT   = 16'h0001;
  localparam logic [15:0] SEED_RIGHT  = 16'h8000;
  localparam logic [15:0] SEED_BOUNCE = 16'h0001;
  localparam logic [15:0] SEED_BLINK  = 16'hFFFF;
  localparam int SPD_W = 2;
  function automatic logic [15:0] mode_seed(input mode_e m);
    return m == M_RIGHT ? SEED_RIGHT : m == M_BOUNCE ? SEED_BOUNCE : m == M_BLINK ? SEED_BLINK : SEED_LEFT;
  endfunction
  function automatic mode_e mode_next(input mode_e m);
`ifdef LED_SEQ_BLINK_EN
    return mode_e'(m + 2'd1);
`else
    return m == M_BOUNCE ? M_LEFT : mode_e'(m + 2'd1);
`endif
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debouncer and registered rising-edge press pulse
// Ports: clk, rst_n (async active-low), btn_i (raw async button), press_pulse (one-cycle step)
module btn_debounce #(
  parameter int DEB_NUM = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_pulse
);
  localparam int CW = $clog2(DEB_NUM + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          stable_q;
  logic          prev_q;
  logic          diff;
  logic          done;
  assign diff = sync_q[1] != stable_q;
  assign done = cnt_q == CW'(DEB_NUM - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      stable_q    <= 1'b0;
      prev_q      <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      // any cycle agreeing with the stable level restarts the count
      cnt_q       <= (!diff || done) ? '0 : cnt_q + 1'b1;
      stable_q    <= (diff && done) ? sync_q[1] : stable_q;
      prev_q      <= stable_q;
      press_pulse <= stable_q & ~prev_q;
    end
  end
endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: multi-mode 16-LED pattern sequencer with programmable step rate and debounced mode button
// Ports: CLK100MHZ, CPU_RESETN (async active-low), SW[0] pause, SW[2:1] speed, BTNC mode button,
//        LED pattern (registered), MODE current mode (registered). Build option: LED_SEQ_BLINK_EN.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int DIV_NUM = 50_000_000,
  parameter int DEB_NUM = 1_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] SW,
  input  logic        BTNC,
  output logic [15:0] LED,
  output logic [1:0]  MODE
);
  localparam int CW = $clog2(DIV_NUM);
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lim;
  mode_e         mode_q;
  mode_e         mode_d;
  logic          dir_q;
  logic          step;
  logic          tick;
  logic          go_right;
  logic [15:0]   rol;
  logic [15:0]   ror;
  logic [15:0]   nxt;
  logic          unused_sw;
  assign unused_sw = ^SW[15:3];
  btn_debounce #(.DEB_NUM(DEB_NUM)) u_deb (
    .clk        (CLK100MHZ),
    .rst_n      (CPU_RESETN),
    .btn_i      (BTNC),
    .press_pulse(step)
  );
  assign lim = CW'((DIV_NUM >> SW[SPD_W:1]) - 1);
  // >= rather than == so a speed-up past the current count ticks at once
  assign tick = !SW[0] && cnt_q >= lim;
  assign rol = {LED[14:0], LED[15]};
  assign ror = {LED[0], LED[15:1]};
  // dir_q=1 means moving right; reverse when the lit bit reaches the end it is moving toward
  assign go_right = dir_q ^ (dir_q ? LED[0] : LED[15]);
  assign mode_d = mode_next(mode_q);
  always_comb begin
`ifdef LED_SEQ_BLINK_EN
    nxt = mode_q == M_LEFT ? rol : mode_q == M_RIGHT ? ror : mode_q == M_BOUNCE ? (go_right ? ror : rol) : ~LED;
`else
    nxt = mode_q == M_LEFT ? rol : mode_q == M_RIGHT ? ror : mode_q == M_BOUNCE ? (go_right ? ror : rol) : LED;
`endif
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      mode_q <= M_LEFT;
      LED    <= SEED_LEFT;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (step) begin
      mode_q <= mode_d;
      LED    <= mode_seed(mode_d);
      dir_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (tick) begin
      LED    <= nxt;
      dir_q  <= mode_q == M_BOUNCE ? go_right : dir_q;
      cnt_q  <= '0;
    end else if (!SW[0]) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end
  assign MODE = mode_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboard bench for led_pattern_seq with DIV_NUM=8, DEB_NUM=4
module tb_led_pattern_seq;
  typedef struct {
    int          cyc;
    logic [15:0] led;
    logic [1:0]  mode;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        btn = 1'b0;
  logic [15:0] led;
  logic [1:0]  mode;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          p0;
  exp_t        q[$];
  led_pattern_seq #(.DIV_NUM(8), .DEB_NUM(4)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .BTNC      (btn),
    .LED       (led),
    .MODE      (mode)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic exp_at(input int c, input logic [15:0] l, input logic [1:0] m);
    q.push_back('{cyc: c, led: l, mode: m});
  endtask
  function automatic logic [15:0] bnc(input int k);
    int p;
    p = k % 30;
    return p <= 15 ? 16'(1) << p : 16'(1) << (30 - p);
  endfunction
  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("stale", e.cyc, cyc);
    end
    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("led", led, e.led);
      check("mode", mode, e.mode);
    end
  end
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("drain", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask
  task automatic press_btn();
    btn = 1'b1;
    repeat (10) edge_step();
    btn = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    #100;
    check("rst_led", led, 16'h0001);
    check("rst_mode", mode, 2'd0);
    edge_step();
    rst_n = 1'b1;
    p0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      exp_at(p0 + 8 * k - 1, 16'(1) << ((k - 1) % 16), 2'd0);
      exp_at(p0 + 8 * k, 16'(1) << (k % 16), 2'd0);
    end
    drain(200);
    repeat (3) edge_step();
    p0 = cyc;
    exp_at(p0 + 1, 16'h0001, 2'd0);
    exp_at(p0 + 100, 16'h0001, 2'd0);
    exp_at(p0 + 200, 16'h0001, 2'd0);
    exp_at(p0 + 204, 16'h0001, 2'd0);
    exp_at(p0 + 205, 16'h0002, 2'd0);
    sw = 16'h0001;
    repeat (200) edge_step();
    sw = 16'h0000;
    drain(50);
    edge_step();
    p0 = cyc;
    exp_at(p0 + 7, 16'h0004, 2'd0);
    exp_at(p0 + 8, 16'h8000, 2'd1);
    exp_at(p0 + 15, 16'h8000, 2'd1);
    exp_at(p0 + 16, 16'h4000, 2'd1);
    press_btn();
    drain(50);
    edge_step();
    p0 = cyc;
    exp_at(p0 + 6, 16'h4000, 2'd1);
    exp_at(p0 + 7, 16'h2000, 2'd1);
    exp_at(p0 + 12, 16'h2000, 2'd1);
    exp_at(p0 + 15, 16'h1000, 2'd1);
    btn = 1'b1;
    repeat (2) edge_step();
    btn = 1'b0;
    drain(50);
    edge_step();
    p0 = cyc;
    exp_at(p0 + 8, 16'h0001, 2'd2);
    for (int k = 1; k <= 32; k++) exp_at(p0 + 8 + 8 * k, bnc(k), 2'd2);
    press_btn();
    drain(400);
    edge_step();
    p0 = cyc;
    for (int j = 1; j <= 6; j++) exp_at(p0 + j, bnc(32 + j), 2'd2);
    exp_at(p0 + 13, bnc(38), 2'd2);
    exp_at(p0 + 14, bnc(39), 2'd2);
    sw = 16'h0006;
    repeat (6) edge_step();
    sw = 16'h0000;
    drain(50);
    repeat (5) edge_step();
    p0 = cyc;
    exp_at(p0 + 1, bnc(40), 2'd2);
    exp_at(p0 + 8, bnc(40), 2'd2);
    exp_at(p0 + 9, bnc(41), 2'd2);
    sw = 16'h0006;
    edge_step();
    sw = 16'h0000;
    drain(50);
    edge_step();
    p0 = cyc;
`ifdef LED_SEQ_BLINK_EN
    exp_at(p0 + 8, 16'hFFFF, 2'd3);
    exp_at(p0 + 16, 16'h0000, 2'd3);
`else
    exp_at(p0 + 8, 16'h0001, 2'd0);
    exp_at(p0 + 16, 16'h0002, 2'd0);
`endif
    press_btn();
    drain(50);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_led", led, 16'h0001);
    check("async_mode", mode, 2'd0);
    repeat (3) @(negedge clk);
    check("hold_led", led, 16'h0001);
    edge_step();
    rst_n = 1'b1;
    p0 = cyc;
    exp_at(p0 + 7, 16'h0001, 2'd0);
    exp_at(p0 + 8, 16'h0002, 2'd0);
    drain(50);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
